// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared encodings and helpers for the BCD digit scanner
package bcd_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // Counter width: enough bits to hold (longest phase length - 1)
    function automatic int cnt_width(input int clk_div, input int dead_cycles);
        int m;
        m = clk_div;
        if (dead_cycles > m) m = dead_cycles;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/bcd_phase_cnt.sv
// rtl/bcd_phase_cnt.sv - phase length counter with end-of-phase pulse
module bcd_phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic         done
);

    logic [W-1:0] cnt;

    // done marks the final cycle of the current phase (cnt reached length-1)
    assign done = (cnt == last);

    // Count up, restarting at zero when a phase ends or the scan is halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - 4-digit multiplexed display scanner with tear-free update buffer
module bcd_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int              CW         = cnt_width(CLK_DIV, DEAD_CYCLES);
    localparam int              IW         = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0]   SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   BLANK_LAST = (DEAD_CYCLES == 0) ? '0 : CW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t   state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [15:0]   act, act_nxt;
    logic [15:0]   pend;
    logic          pend_full;
    logic          done;
    logic          frame_end;
    logic          swap;
    logic [CW-1:0] phase_last;
    logic [3:0]    an_nxt;
    logic [3:0]    digit_nxt;

    // BLANK after a halt/reset lasts one cycle when blanking is disabled
    assign phase_last = (state == ST_SHOW) ? SHOW_LAST : BLANK_LAST;

    bcd_phase_cnt #(.W(CW)) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~en),
        .last  (phase_last),
        .done  (done)
    );

    assign frame_end = en && (state == ST_SHOW) && (idx == IDX_LAST) && done;
    // New data only lands on a frame boundary, or at once while the display is halted
    assign swap      = pend_full && (frame_end || !en);
    assign upd_ready = ~pend_full;

    // Next scan position, next active value and the output pattern they imply
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        act_nxt   = swap ? pend : act;
        if (!en) begin
            state_nxt = ST_BLANK;
            idx_nxt   = '0;
        end else if (done) begin
            if (state == ST_BLANK) begin
                state_nxt = ST_SHOW;
            end else begin
                idx_nxt   = idx + 1'b1;
                state_nxt = (DEAD_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            end
        end
        an_nxt    = (state_nxt == ST_SHOW) ? ~(4'b0001 << idx_nxt) : AN_OFF;
        digit_nxt = act_nxt[{idx_nxt, 2'b00} +: 4];
    end

    // Scan FSM with registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            idx        <= '0;
            an         <= AN_OFF;
            digit      <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            digit      <= digit_nxt;
            frame_tick <= frame_end;
        end
    end

    // Pending/active double buffer with valid/ready capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act       <= 16'h0000;
            pend      <= 16'h0000;
            pend_full <= 1'b0;
        end else begin
            act <= act_nxt;
            if (upd_valid && !pend_full) begin
                pend      <= upd_data;
                pend_full <= 1'b1;
            end else if (swap) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule
